// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select: data has priority unless fetch has waited through a full data streak.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int STK_W      = 3
) (
    input  logic             f_req,
    input  logic             d_req,
    input  logic [STK_W-1:0] streak,
    output logic             pick_f,
    output logic             pick_d
);

    logic starve_s;

    // Combinational priority decision.
    always_comb begin
        starve_s = f_req && (streak == STK_W'(MAX_STREAK));
        pick_d   = d_req && !starve_s;
        pick_f   = f_req && !pick_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the fetch unit and the load/store unit.
// Optional MEM_ARB_STATS_EN adds saturating grant/stall counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stat_f_grants,
    output logic [15:0]       stat_d_grants,
    output logic [15:0]       stat_f_stall
);

    localparam int LAT_W = cnt_width(MEM_LAT);
    localparam int STK_W = cnt_width(MAX_STREAK);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

    arb_state_t       state_r;
    arb_state_t       state_nxt_s;
    arb_owner_t       owner_r;
    logic [LAT_W-1:0] lat_cnt_r;
    logic [STK_W-1:0] streak_r;
    logic             pick_f_s;
    logic             pick_d_s;
    logic             capture_s;

    mem_arb_pick #(
        .MAX_STREAK (MAX_STREAK),
        .STK_W      (STK_W)
    ) u_pick (
        .f_req  (f_req),
        .d_req  (d_req),
        .streak (streak_r),
        .pick_f (pick_f_s),
        .pick_d (pick_d_s)
    );

    // Next-state logic; the enable cycle is not part of the latency count,
    // so the read data is taken MEM_LAT cycles after mem_en.
    always_comb begin
        capture_s   = (state_r == ST_WAIT) && !mem_en && (lat_cnt_r == LAT_W'(1));
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_f_s || pick_d_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (capture_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Issue, latency count, response capture and streak tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_gnt     <= 1'b0;
            f_valid   <= 1'b0;
            f_rdata   <= {DATA_W{1'b0}};
            d_gnt     <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= {DATA_W{1'b0}};
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            owner_r   <= OWN_F;
            lat_cnt_r <= {LAT_W{1'b0}};
            streak_r  <= {STK_W{1'b0}};
        end else begin
            f_gnt   <= 1'b0;
            d_gnt   <= 1'b0;
            f_valid <= 1'b0;
            d_valid <= 1'b0;
            mem_en  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_d_s) begin
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        d_gnt     <= 1'b1;
                        owner_r   <= OWN_D;
                        lat_cnt_r <= LAT_LOAD;
                        // Only grants that make fetch wait count toward the streak.
                        if (!f_req) begin
                            streak_r <= {STK_W{1'b0}};
                        end else if (streak_r != STK_MAX) begin
                            streak_r <= streak_r + STK_W'(1);
                        end
                    end else if (pick_f_s) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= f_addr;
                        mem_wdata <= {DATA_W{1'b0}};
                        f_gnt     <= 1'b1;
                        owner_r   <= OWN_F;
                        lat_cnt_r <= LAT_LOAD;
                        streak_r  <= {STK_W{1'b0}};
                    end
                end
                ST_WAIT: begin
                    if (!mem_en) begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                    if (capture_s) begin
                        if (owner_r == OWN_F) begin
                            f_rdata <= mem_rdata;
                            f_valid <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                            d_valid <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    lat_cnt_r <= {LAT_W{1'b0}};
                end
                default: begin
                    lat_cnt_r <= {LAT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating grant and fetch-stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_f_grants <= 16'h0000;
            stat_d_grants <= 16'h0000;
            stat_f_stall  <= 16'h0000;
        end else begin
            if ((state_r == ST_IDLE) && pick_f_s) begin
                stat_f_grants <= sat_inc(stat_f_grants);
            end
            if ((state_r == ST_IDLE) && pick_d_s) begin
                stat_d_grants <= sat_inc(stat_d_grants);
            end
            if (f_req && !f_valid) begin
                stat_f_stall <= sat_inc(stat_f_stall);
            end
        end
    end
`else
    assign stat_f_grants = 16'h0000;
    assign stat_d_grants = 16'h0000;
    assign stat_f_stall  = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level schedule model and an emulated synchronous memory.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MS  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_gnt, f_valid;
    logic [DW-1:0] f_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stat_f_grants, stat_d_grants, stat_f_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .MEM_LAT (LAT), .MAX_STREAK (MS)
    ) dut (
        .clk (clk), .rst (rst),
        .f_req (f_req), .f_addr (f_addr), .f_gnt (f_gnt), .f_valid (f_valid), .f_rdata (f_rdata),
        .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
        .d_gnt (d_gnt), .d_valid (d_valid), .d_rdata (d_rdata),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stat_f_grants (stat_f_grants), .stat_d_grants (stat_d_grants), .stat_f_stall (stat_f_stall)
    );

    function automatic logic [31:0] init_word(input int a);
        return (a == 16) ? 32'hDEADBEEF : (32'hA5A5_0000 + 32'(a) * 32'h0000_0103);
    endfunction

    // Emulated memory macro: read data appears LAT cycles after mem_en.
    logic [DW-1:0] bmem [0:63];
    bit            bwr  [0:63];
    logic [DW-1:0] pipe [0:LAT-1];
    assign mem_rdata = pipe[LAT-1];

    function automatic logic [31:0] bmem_rd(input int a);
        return bwr[a] ? bmem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            bmem[int'(mem_addr[5:0])] <= mem_wdata;
            bwr[int'(mem_addr[5:0])]  <= 1'b1;
        end
        pipe[0] <= (mem_en && !mem_we) ? bmem_rd(int'(mem_addr[5:0])) : $urandom;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: one outstanding transaction scheduled by cycle number.
    logic [31:0] ref_mem [0:63];
    int          free_cyc, streak, own, gnt_cyc, val_cyc;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        p_we;
    logic [31:0] exp_f_rdata, exp_d_rdata;
    int          st_fg, st_dg, st_stall;
    bit          exp_fv_cur, keep_f, keep_d, rnd_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_decide();
        if (cyc >= free_cyc) begin
            if (d_req && !(f_req && streak == MS)) begin
                own = 2; p_addr = d_addr; p_we = d_we; p_wdata = d_wdata;
                if (d_we) begin
                    ref_mem[int'(d_addr[5:0])] = d_wdata;
                    p_rdata = 32'h0;
                end else begin
                    p_rdata = ref_mem[int'(d_addr[5:0])];
                end
                streak = f_req ? ((streak < MS) ? streak + 1 : MS) : 0;
                st_dg++;
            end else if (f_req) begin
                own = 1; p_addr = f_addr; p_we = 1'b0; p_wdata = 32'h0;
                p_rdata = ref_mem[int'(f_addr[5:0])];
                streak = 0;
                st_fg++;
            end
            if (d_req || f_req) begin
                gnt_cyc  = cyc + 1;
                val_cyc  = cyc + 2 + LAT;
                free_cyc = cyc + 3 + LAT;
            end else begin
                free_cyc = cyc + 1;
            end
        end
    endtask

    task automatic check_cycle();
        bit fg, dg, en, fv, dv;
        fg = (own == 1) && (cyc == gnt_cyc);
        dg = (own == 2) && (cyc == gnt_cyc);
        en = fg || dg;
        fv = (own == 1) && (cyc == val_cyc);
        dv = (own == 2) && (cyc == val_cyc);
        if (fv) exp_f_rdata = p_rdata;
        if (dv && !p_we) exp_d_rdata = p_rdata;
        chk("f_gnt", f_gnt, fg);
        chk("d_gnt", d_gnt, dg);
        chk("mem_en", mem_en, en);
        chk("f_valid", f_valid, fv);
        chk("d_valid", d_valid, dv);
        chk("f_rdata", f_rdata, exp_f_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (en) begin
            chk("mem_we", mem_we, p_we);
            chk("mem_addr", mem_addr, p_addr);
        end
        if (en && p_we) chk("mem_wdata", mem_wdata, p_wdata);
`ifdef MEM_ARB_STATS_EN
        chk("stat_f_grants", stat_f_grants, 32'(st_fg));
        chk("stat_d_grants", stat_d_grants, 32'(st_dg));
        chk("stat_f_stall", stat_f_stall, 32'(st_stall));
`else
        chk("stat_f_grants", stat_f_grants, 32'h0);
        chk("stat_d_grants", stat_d_grants, 32'h0);
        chk("stat_f_stall", stat_f_stall, 32'h0);
`endif
        exp_fv_cur = fv;
    endtask

    task automatic drive_reqs();
        if (f_req && own == 1 && cyc == val_cyc && !keep_f) f_req = 1'b0;
        if (d_req && own == 2 && cyc == val_cyc && !keep_d) d_req = 1'b0;
        if (rnd_mode) begin
            if (f_req && own == 1 && cyc > gnt_cyc && cyc < val_cyc && $urandom_range(9) == 0) f_req = 1'b0;
            if (d_req && own == 2 && cyc > gnt_cyc && cyc < val_cyc && $urandom_range(9) == 0) d_req = 1'b0;
            if (!f_req && $urandom_range(2) == 0) begin
                f_req = 1'b1;
                f_addr = 32'($urandom_range(63));
            end
            if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1'b1;
                d_we = 1'($urandom_range(1));
                d_addr = 32'($urandom_range(63));
                d_wdata = $urandom;
            end
        end
    endtask

    task automatic step();
        model_decide();
        if (f_req && !exp_fv_cur) st_stall++;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle();
        drive_reqs();
    endtask

    task automatic do_reset();
        f_req = 1'b0;
        d_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("rst_f_gnt", f_gnt, 32'h0);
        chk("rst_f_valid", f_valid, 32'h0);
        chk("rst_f_rdata", f_rdata, 32'h0);
        chk("rst_d_gnt", d_gnt, 32'h0);
        chk("rst_d_valid", d_valid, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_en", mem_en, 32'h0);
        chk("rst_mem_we", mem_we, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stats", {stat_f_grants, stat_d_grants | stat_f_stall}, 32'h0);
        rst = 1'b0;
        own = 0; streak = 0; gnt_cyc = -10; val_cyc = -10; free_cyc = cyc;
        exp_f_rdata = 32'h0; exp_d_rdata = 32'h0; exp_fv_cur = 1'b0;
        st_fg = 0; st_dg = 0; st_stall = 0;
        keep_f = 1'b0; keep_d = 1'b0; rnd_mode = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (f_req || d_req || cyc < free_cyc); k++) step();
        chk("drain_idle", {30'h0, f_req, d_req}, 32'h0);
    endtask

    initial begin
        int t0, g, v, g2, nf, ng;
        logic [31:0] rd, prev;
        logic [5:0]  seq;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        do_reset();

        // Lone fetch from 0x10.
        t0 = cyc; f_req = 1'b1; f_addr = 32'h10; g = -1; v = -1; rd = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (f_gnt === 1'b1 && g < 0) g = cyc - t0;
            if (f_valid === 1'b1 && v < 0) begin v = cyc - t0; rd = f_rdata; end
        end
        chk("lone_gnt_lat", g, 32'd1);
        chk("lone_valid_lat", v, 32'(LAT + 2));
        chk("lone_rdata", rd, 32'hDEADBEEF);

        // Store 5 to 0x20, then load it back.
        t0 = cyc; prev = exp_d_rdata; v = -1; rd = '0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5;
        for (int k = 0; k < 12 && v < 0; k++) begin
            step();
            if (d_valid === 1'b1) begin v = cyc - t0; rd = d_rdata; end
        end
        chk("store_ack_lat", v, 32'(LAT + 2));
        chk("store_rdata_keep", rd, prev);
        step();
        t0 = cyc; v = -1; rd = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int k = 0; k < 12 && v < 0; k++) begin
            step();
            if (d_valid === 1'b1) begin v = cyc - t0; rd = d_rdata; end
        end
        chk("load_lat", v, 32'(LAT + 2));
        chk("load_rdata", rd, 32'h5);
        drain();

        // Simultaneous requests: data first, fetch at the following IDLE.
        t0 = cyc; g = -1; g2 = -1;
        f_req = 1'b1; f_addr = 32'h21; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h11;
        for (int k = 0; k < 24 && g2 < 0; k++) begin
            step();
            if (d_gnt === 1'b1 && g < 0) g = cyc - t0;
            if (f_gnt === 1'b1 && g2 < 0) g2 = cyc - t0;
        end
        chk("simul_d_first", g, 32'd1);
        chk("simul_f_next", g2, 32'(LAT + 4));
        drain();

        // Starvation guard and statistics over two fetch grants.
        do_reset();
        keep_f = 1'b1; keep_d = 1'b1;
        f_req = 1'b1; f_addr = 32'h3; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h9;
        nf = 0; ng = 0; seq = '0;
        for (int k = 0; k < 200 && nf < 2; k++) begin
            step();
            if (d_gnt === 1'b1) begin
                if (ng < 6) seq = {seq[4:0], 1'b1};
                ng++;
            end
            if (f_gnt === 1'b1) begin
                if (ng < 6) seq = {seq[4:0], 1'b0};
                ng++;
                nf++;
            end
        end
        chk("starve_seq", 32'(seq), 32'h3D);
        chk("starve_fgrants", nf, 32'd2);
`ifdef MEM_ARB_STATS_EN
        chk("stats_f_grants", stat_f_grants, 32'd2);
        chk("stats_d_grants", stat_d_grants, 32'd8);
        chk("stats_f_stall", stat_f_stall, 32'(st_stall));
`else
        chk("stats_tied_off", {stat_f_grants, stat_d_grants | stat_f_stall}, 32'h0);
`endif
        keep_f = 1'b0; keep_d = 1'b0;
        drain();

        // Reset during WAIT aborts the fetch.
        f_req = 1'b1; f_addr = 32'h5;
        step();
        step();
        do_reset();
        for (int k = 0; k < 6; k++) step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        drain();

        // Random traffic.
        rnd_mode = 1'b1;
        for (int k = 0; k < 700; k++) step();
        rnd_mode = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous instruction/data memory between the MiniRISC fetch unit and the load/store unit.
- Data accesses get priority. A streak limit guarantees fetch forward progress.
- Handles one transaction at a time: request, registered issue, fixed memory latency, registered response.
- Sits between the core control path (which stalls on pending valid) and the memory macro.

Parameters:
- ADDR_W, 32, word-address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (≥1).
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- f_req  in  1  fetch request, held until f_valid
- f_addr  in  ADDR_W  fetch address, stable while f_req
- f_gnt  out  1  one-cycle pulse when fetch is issued to memory
- f_valid  out  1  one-cycle pulse, f_rdata valid
- f_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  issue pulse for data
- d_valid  out  1  load data / store ack pulse
- d_rdata  out  DATA_W  load result
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs are 0, including rdata registers. State IDLE, streak = 0, latency counter = 0.
- A reset mid-transaction aborts it: no valid is pulsed and the memory result is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Winner selection: if d_req and not (f_req and streak==MAX_STREAK), data wins. Else if f_req, fetch wins.
  - On a win, register mem_en=1, mem_addr, mem_we (d_we for data, 0 for fetch) and mem_wdata. Pulse the winner's gnt. Latch the owner and load the counter with MEM_LAT. Go to WAIT.
- WAIT:
  - mem_en is high only in the first WAIT cycle.
  - The counter decrements each cycle. When it reads 1, capture mem_rdata into the owner's rdata (loads/fetches only; store leaves d_rdata unchanged). Go to RESP.
- RESP: pulse the owner's valid for one cycle. Requests are ignored in this cycle. Go to IDLE.
- Latency: req sampled in cycle t gives gnt and mem_en in t+1, valid in t+2+MEM_LAT, and IDLE again in t+3+MEM_LAT.
- Streak counter:
  - Increments on each data grant made while f_req is high.
  - Cleared on a fetch grant, and on a data grant made while f_req is low.
  - Saturates at MAX_STREAK.
- Simultaneous f_req and d_req with streak < MAX_STREAK: data is granted.
- Requester drops req mid-transaction: the transaction completes and valid still pulses. Requesters must tolerate this.
- Requests arriving in WAIT/RESP are held (level) and arbitrated in the next IDLE.
- Store to any address: d_valid acts as the write ack at the same latency as a load.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- With the macro: adds outputs stat_f_grants, stat_d_grants and stat_f_stall, each 16-bit saturating at 16'hFFFF, cleared by rst.
  - stat_f_grants and stat_d_grants count grants.
  - stat_f_stall counts cycles with f_req high and no f_valid.
- Without the macro: the ports exist but are tied to 0 and no counter logic is generated.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding (IDLE/WAIT/RESP).
  - Owner encoding (OWN_F/OWN_D).
  - Default ADDR_W/DATA_W.
  - Counter widths derived from MEM_LAT and MAX_STREAK.
- One sub-module, mem_arb_pick: combinational winner select from f_req, d_req, streak and MAX_STREAK. The FSM and datapath registers stay in the top module.

Test Plan:
- Reset mid-op: fetch issued, rst pulsed in WAIT → no f_valid; all outputs 0 the next cycle; IDLE.
- Lone fetch, MEM_LAT=1: f_req at t0, addr 0x10, memory returns 0xDEADBEEF → f_gnt and mem_en at t0+1; f_valid with f_rdata=0xDEADBEEF at t0+3.
- Store then load, MEM_LAT=2: store 0x5 to addr 0x20, then load from 0x20.
  - Store: d_valid arrives 4 cycles after d_req; d_rdata unchanged.
  - Load: d_rdata=0x5.
- Simultaneous requests: f_req and d_req both held from t0 → d_gnt first; f_gnt at the next IDLE.
- Starvation, MAX_STREAK=4: d_req held continuously with f_req high → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Stats (MEM_ARB_STATS_EN): run the starvation scenario for 2 fetch grants → stat_f_grants=2; stat_d_grants=8; stat_f_stall equals the counted stall cycles.
